// File: rtl/keypad_pkg.sv
// Shared definitions for the 3x4 keypad scanner: key codes, matrix geometry,
// column index encoding, debounce state encoding and the scan accumulator.
package keypad_pkg;

   localparam int unsigned NUM_COLS = 3;
   localparam int unsigned NUM_ROWS = 4;
   localparam int unsigned CODE_W   = 4;

   typedef logic [CODE_W-1:0] key_code_t;

   localparam key_code_t KEY_0  = 4'd0;
   localparam key_code_t KEY_1  = 4'd1;
   localparam key_code_t KEY_2  = 4'd2;
   localparam key_code_t KEY_3  = 4'd3;
   localparam key_code_t KEY_4  = 4'd4;
   localparam key_code_t KEY_5  = 4'd5;
   localparam key_code_t KEY_6  = 4'd6;
   localparam key_code_t KEY_7  = 4'd7;
   localparam key_code_t KEY_8  = 4'd8;
   localparam key_code_t KEY_9  = 4'd9;
   localparam key_code_t NO_KEY = 4'hF;

   typedef enum logic [1:0] {
      COL_A = 2'd0,
      COL_B = 2'd1,
      COL_C = 2'd2
   } col_idx_t;

   typedef enum logic [1:0] {
      DB_IDLE    = 2'd0,
      DB_CAND    = 2'd1,
      DB_HELD    = 2'd2,
      DB_RELEASE = 2'd3
   } db_state_t;

   // hits saturates at 2: the scan only needs to know zero / one / many
   typedef struct packed {
      logic [1:0] hits;
      key_code_t  code;
   } scan_acc_t;

endpackage

// File: rtl/keypad_col_decode.sv
// Combinational matrix-to-code table for one driven column.
//   col_idx  : column currently strobed
//   rows     : {row_g, row_f, row_e, row_d} as sampled
//   code_c   : code of the valid contact (NO_KEY if none)
//   hit_c    : at least one valid contact in this column
//   multi_c  : two or more valid contacts in this column
module keypad_col_decode
   import keypad_pkg::*;
(
   input  col_idx_t              col_idx,
   input  logic [NUM_ROWS-1:0]   rows,
   output key_code_t             code_c,
   output logic                  hit_c,
   output logic                  multi_c
);

   logic [NUM_ROWS-1:0] valid;

   function automatic key_code_t key_lookup(input col_idx_t c, input int r);
      key_code_t k;
      k = NO_KEY;
      case (c)
         COL_A: case (r) 0: k = KEY_1; 1: k = KEY_4; 2: k = KEY_7; default: k = NO_KEY; endcase
         COL_B: case (r) 0: k = KEY_2; 1: k = KEY_5; 2: k = KEY_8; default: k = KEY_0;  endcase
         COL_C: case (r) 0: k = KEY_3; 1: k = KEY_6; 2: k = KEY_9; default: k = NO_KEY; endcase
         default: k = NO_KEY;
      endcase
      return k;
   endfunction

   // Row g only forms a key under column b; (a,g) and (c,g) are masked out
   always_comb begin
      valid   = rows & {col_idx == COL_B, 3'b111};
      hit_c   = |valid;
      multi_c = |(valid & (valid - NUM_ROWS'(1)));
      code_c  = NO_KEY;
      for (int r = int'(NUM_ROWS) - 1; r >= 0; r--) begin
         if (valid[r]) code_c = key_lookup(col_idx, r);
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Keypad matrix scanner: strobes columns a/b/c in turn, samples rows at the end
// of each column's settle window, resolves one code per full scan (ghosting
// rejected) and debounces across scans into press/release events.
//   clk, reset          : clock, synchronous active-high reset
//   col_a/b/c           : column strobes (registered, one-hot outside reset)
//   row_d/e/f/g         : synchronised row senses
//   key_valid           : one-cycle pulse on debounced press
//   key_number          : code of held / last key
//   key_held            : high from press until debounced release
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned DEBOUNCE_SCANS = 3
)(
   input  logic              clk,
   input  logic              reset,
   output logic              col_a,
   output logic              col_b,
   output logic              col_c,
   input  logic              row_d,
   input  logic              row_e,
   input  logic              row_f,
   input  logic              row_g,
   output logic              key_valid,
   output logic [CODE_W-1:0] key_number,
   output logic              key_held
);

   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned DB_W  = $clog2(DEBOUNCE_SCANS + 1);

   logic               active_q,     active_d;
   col_idx_t           col_idx_q,    col_idx_d;
   logic [SET_W-1:0]   settle_q,     settle_d;
   logic [2:0]         col_oh_q,     col_oh_d;
   scan_acc_t          acc_q,        acc_d;
   db_state_t          state_q,      state_d;
   logic [DB_W-1:0]    cnt_q,        cnt_d;
   key_code_t          cand_q,       cand_d;
   logic               key_valid_q,  key_valid_d;
   key_code_t          key_number_q, key_number_d;
   logic               key_held_q,   key_held_d;

   logic       sample_c;
   logic       scan_done_c;
   key_code_t  dec_code_c;
   logic       dec_hit_c;
   logic       dec_multi_c;
   scan_acc_t  acc_merged_c;
   key_code_t  scan_result_c;

   keypad_col_decode u_decode (
      .col_idx (col_idx_q),
      .rows    ({row_g, row_f, row_e, row_d}),
      .code_c  (dec_code_c),
      .hit_c   (dec_hit_c),
      .multi_c (dec_multi_c)
   );

   // Column sequencer: first post-reset cycle starts column a
   always_comb begin
      active_d    = active_q;
      col_idx_d   = col_idx_q;
      settle_d    = settle_q;
      col_oh_d    = col_oh_q;
      sample_c    = 1'b0;
      scan_done_c = 1'b0;
      if (!active_q) begin
         active_d  = 1'b1;
         col_idx_d = COL_A;
         settle_d  = '0;
         col_oh_d  = 3'b001;
      end else if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
         sample_c = 1'b1;
         settle_d = '0;
         case (col_idx_q)
            COL_A:   begin col_idx_d = COL_B; col_oh_d = 3'b010; end
            COL_B:   begin col_idx_d = COL_C; col_oh_d = 3'b100; end
            default: begin col_idx_d = COL_A; col_oh_d = 3'b001; scan_done_c = 1'b1; end
         endcase
      end else begin
         settle_d = settle_q + SET_W'(1);
      end
   end

   // Scan accumulator: exactly one valid contact per scan yields a code
   always_comb begin
      acc_merged_c = acc_q;
      if (sample_c) begin
         if (dec_multi_c) begin
            acc_merged_c.hits = 2'd2;
         end else if (dec_hit_c) begin
            acc_merged_c.hits = (acc_q.hits == 2'd0) ? 2'd1 : 2'd2;
            acc_merged_c.code = dec_code_c;
         end
      end
      scan_result_c = (acc_merged_c.hits == 2'd1) ? acc_merged_c.code : NO_KEY;
      acc_d         = scan_done_c ? '0 : acc_merged_c;
   end

   // Debounce FSM, advanced only on scan results
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cand_d       = cand_q;
      key_valid_d  = 1'b0;
      key_number_d = key_number_q;
      key_held_d   = key_held_q;
      if (scan_done_c) begin
         case (state_q)
            DB_IDLE: begin
               if (scan_result_c != NO_KEY) begin
                  if (DEBOUNCE_SCANS <= 1) begin
                     state_d      = DB_HELD;
                     cnt_d        = '0;
                     key_valid_d  = 1'b1;
                     key_number_d = scan_result_c;
                     key_held_d   = 1'b1;
                  end else begin
                     state_d = DB_CAND;
                     cand_d  = scan_result_c;
                     cnt_d   = DB_W'(1);
                  end
               end
            end
            DB_CAND: begin
               if (scan_result_c == NO_KEY) begin
                  state_d = DB_IDLE;
                  cnt_d   = '0;
               end else if (scan_result_c == cand_q) begin
                  if (cnt_q == DB_W'(DEBOUNCE_SCANS - 1)) begin
                     state_d      = DB_HELD;
                     cnt_d        = '0;
                     key_valid_d  = 1'b1;
                     key_number_d = scan_result_c;
                     key_held_d   = 1'b1;
                  end else begin
                     cnt_d = cnt_q + DB_W'(1);
                  end
               end else begin
                  cand_d = scan_result_c;
                  cnt_d  = DB_W'(1);
               end
            end
            DB_HELD: begin
               if (scan_result_c == NO_KEY) begin
                  if (DEBOUNCE_SCANS <= 1) begin
                     state_d    = DB_IDLE;
                     key_held_d = 1'b0;
                  end else begin
                     state_d = DB_RELEASE;
                     cnt_d   = DB_W'(1);
                  end
               end
            end
            default: begin
               if (scan_result_c != NO_KEY) begin
                  state_d = DB_HELD;
                  cnt_d   = '0;
               end else if (cnt_q == DB_W'(DEBOUNCE_SCANS - 1)) begin
                  state_d    = DB_IDLE;
                  cnt_d      = '0;
                  key_held_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + DB_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active_q     <= 1'b0;
         col_idx_q    <= COL_A;
         settle_q     <= '0;
         col_oh_q     <= '0;
         acc_q        <= '0;
         state_q      <= DB_IDLE;
         cnt_q        <= '0;
         cand_q       <= NO_KEY;
         key_valid_q  <= 1'b0;
         key_number_q <= '0;
         key_held_q   <= 1'b0;
      end else begin
         active_q     <= active_d;
         col_idx_q    <= col_idx_d;
         settle_q     <= settle_d;
         col_oh_q     <= col_oh_d;
         acc_q        <= acc_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cand_q       <= cand_d;
         key_valid_q  <= key_valid_d;
         key_number_q <= key_number_d;
         key_held_q   <= key_held_d;
      end
   end

   assign col_a      = col_oh_q[0];
   assign col_b      = col_oh_q[1];
   assign col_c      = col_oh_q[2];
   assign key_valid  = key_valid_q;
   assign key_number = key_number_q;
   assign key_held   = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a virtual key matrix answers the DUT's column
// strobes; a scan-level reference model predicts strobes and key events.
module tb_keypad_scanner;

   localparam int S    = 4;
   localparam int DS   = 3;
   localparam int SCAN = 3 * S;
   localparam int NONE = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       col_a, col_b, col_c;
   logic       row_d, row_e, row_f, row_g;
   logic       key_valid;
   logic [3:0] key_number;
   logic       key_held;

   // pressed bit index = col*4 + row  (col a=0,b=1,c=2; row d=0,e=1,f=2,g=3)
   logic [11:0] pressed = '0;
   logic [3:0]  rows_c;

   always #5 clk = ~clk;

   always_comb begin
      rows_c = '0;
      if (col_a) rows_c = rows_c | pressed[3:0];
      if (col_b) rows_c = rows_c | pressed[7:4];
      if (col_c) rows_c = rows_c | pressed[11:8];
   end
   assign row_d = rows_c[0];
   assign row_e = rows_c[1];
   assign row_f = rows_c[2];
   assign row_g = rows_c[3];

   keypad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(DS)) dut (
      .clk        (clk),
      .reset      (reset),
      .col_a      (col_a),
      .col_b      (col_b),
      .col_c      (col_c),
      .row_d      (row_d),
      .row_e      (row_e),
      .row_f      (row_f),
      .row_g      (row_g),
      .key_valid  (key_valid),
      .key_number (key_number),
      .key_held   (key_held)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int pulses = 0;

   // reference model state
   bit m_active = 1'b0;
   int k = 0;
   bit m_valid = 1'b0;
   bit m_held = 1'b0;
   int m_number = 0;
   int run_code = NONE;
   int run_len = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int kbit(input int col, input int row);
      return col * 4 + row;
   endfunction

   // A scan reports a key only when exactly one real key contact is closed
   function automatic int scan_result(input logic [11:0] p);
      int n = 0;
      int code = NONE;
      for (int col = 0; col < 3; col++) begin
         for (int row = 0; row < 4; row++) begin
            if (p[kbit(col, row)] && !(row == 3 && col != 1)) begin
               n++;
               code = (row == 3) ? 0 : row * 3 + col + 1;
            end
         end
      end
      return (n == 1) ? code : NONE;
   endfunction

   // Press after DS identical key results while released; release after DS
   // consecutive empty results while held.
   task automatic model_scan(input int res);
      if (res == run_code) run_len++;
      else begin
         run_code = res;
         run_len  = 1;
      end
      if (!m_held && res != NONE && run_len == DS) begin
         m_valid  = 1'b1;
         m_held   = 1'b1;
         m_number = res;
      end else if (m_held && res == NONE && run_len == DS) begin
         m_held = 1'b0;
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         m_active = 1'b0;
         k        = 0;
         m_valid  = 1'b0;
         m_held   = 1'b0;
         m_number = 0;
         run_code = NONE;
         run_len  = 0;
      end else if (!m_active) begin
         m_active = 1'b1;
         k        = 0;
         m_valid  = 1'b0;
      end else begin
         m_valid = 1'b0;
         if (k % SCAN == SCAN - 1) model_scan(scan_result(pressed));
         k++;
      end
   endtask

   task automatic check_outputs();
      int exp_cols;
      exp_cols = m_active ? (1 << ((k / S) % 3)) : 0;
      check_val("cols", int'({col_c, col_b, col_a}), exp_cols);
      check_val("key_valid", int'(key_valid), int'(m_valid));
      check_val("key_held", int'(key_held), int'(m_held));
      check_val("key_number", int'(key_number), m_number);
      if (key_valid) pulses++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   // Leaves the bench at the start of a scan (column a, first cycle)
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic run_scans(input logic [11:0] p, input int n);
      pressed = p;
      repeat (n * SCAN) tick();
   endtask

   function automatic logic [11:0] one_key(input int col, input int row);
      logic [11:0] v;
      v = '0;
      v[kbit(col, row)] = 1'b1;
      return v;
   endfunction

   initial begin
      logic [11:0] prev;
      int sel;

      @(negedge clk);
      check_val("reset_cols", int'({col_c, col_b, col_a}), 0);
      do_reset();

      // idle scans: strobes sequence with no events
      pulses = 0;
      run_scans('0, 2);
      check_val("idle_pulses", pulses, 0);

      // key 5 pressed, held, released
      pulses = 0;
      run_scans(one_key(1, 1), 2);
      check_val("five_early", int'(key_held), 0);
      run_scans(one_key(1, 1), 1);
      check_val("five_held", int'(key_held), 1);
      check_val("five_number", int'(key_number), 5);
      run_scans(one_key(1, 1), 3);
      run_scans('0, 3);
      check_val("five_released", int'(key_held), 0);
      check_val("five_kept", int'(key_number), 5);
      check_val("five_pulses", pulses, 1);

      // (b,g) is key 0; (a,g) is not a key
      run_scans(one_key(1, 3), 3);
      check_val("zero_number", int'(key_number), 0);
      check_val("zero_held", int'(key_held), 1);
      run_scans('0, 3);
      pulses = 0;
      run_scans(one_key(0, 3), 5);
      check_val("ag_pulses", pulses, 0);

      // ghosting: (a,d)+(c,f) rejected, then (a,d) alone becomes key 1
      run_scans(one_key(0, 0) | one_key(2, 2), 4);
      check_val("ghost_pulses", pulses, 0);
      run_scans(one_key(0, 0), 3);
      check_val("ghost_then_one", int'(key_number), 1);
      check_val("ghost_pulses2", pulses, 1);
      run_scans('0, 3);

      // bounce on 5: present, present, absent, present x3
      pulses = 0;
      run_scans(one_key(1, 1), 2);
      run_scans('0, 1);
      run_scans(one_key(1, 1), 2);
      check_val("bounce_early", pulses, 0);
      run_scans(one_key(1, 1), 1);
      check_val("bounce_pulses", pulses, 1);
      run_scans('0, 3);

      // reset in the middle of debouncing key 9
      run_scans(one_key(2, 2), 2);
      pressed = one_key(2, 2);
      repeat (5) tick();
      do_reset();
      check_val("rst_number", int'(key_number), 0);
      pulses = 0;
      run_scans(one_key(2, 2), 2);
      check_val("rst_no_early", pulses, 0);
      run_scans(one_key(2, 2), 1);
      check_val("rst_press", pulses, 1);
      check_val("rst_press_num", int'(key_number), 9);
      run_scans('0, 3);

      // randomised matrix activity
      prev = '0;
      for (int i = 0; i < 150; i++) begin
         logic [11:0] p;
         sel = int'($urandom_range(0, 5));
         case (sel)
            0:       p = '0;
            4:       p = one_key(int'($urandom_range(0, 2)), int'($urandom_range(0, 3))) |
                         one_key(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            5:       p = prev;
            default: p = one_key(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
         endcase
         prev = p;
         run_scans(p, int'($urandom_range(1, 4)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
